// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the uart transmit buffer: data width and the
// encodings of the drain-side handshake FSM.
package uart_tx_fifo_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_WAIT_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_W register array: one synchronous write port and an
// asynchronous (combinational) read port addressed by the read pointer.
module sync_fifo_ram #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are never reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO in front of the uart core: buffers CPU writes and
// feeds them to the uart one frame at a time via transmit/is_transmitting.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              busy,
  output logic              transmit,
  output logic [DATA_W-1:0] tx_byte,
  input  logic              is_transmitting
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;
  logic              r_transmit;
  logic [DATA_W-1:0] r_tx_byte;
  state_t            r_state;

  state_t            w_state_nxt;
  logic              w_push;
  logic              w_pop;
  logic [AW:0]       w_count_nxt;
  logic [DATA_W-1:0] w_rd_data;

  // A write is refused while full even if a pop frees a slot this cycle.
  assign w_push = wr_en & ~r_full & ~flush;

  sync_fifo_ram #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_full   <= 1'b0;
        r_empty  <= 1'b1;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= w_count_nxt;
        r_full  <= (w_count_nxt == FULL_CNT);
        r_empty <= (w_count_nxt == '0);
      end
      r_overflow <= wr_en & r_full & ~flush;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush suppresses a pending pop so the FSM simply stays in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_empty && !flush) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        if (is_transmitting) w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!is_transmitting) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // tx_byte only changes on a pop, so it is held through the whole frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_transmit <= 1'b0;
      r_tx_byte  <= '0;
    end else begin
      r_transmit <= w_pop;
      if (w_pop) r_tx_byte <= w_rd_data;
    end
  end

  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign transmit = r_transmit;
  assign tx_byte  = r_tx_byte;
  assign busy     = (r_state != ST_IDLE) | ~r_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: queue-based reference model, a behavioural
// uart responder and a scoreboard monitor that checks every transmitted byte.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       is_transmitting = 1'b0;
  logic       full, empty, overflow, busy, transmit;
  logic [AW:0] count;
  logic [7:0] tx_byte;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .flush           (flush),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .overflow        (overflow),
    .busy            (busy),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .is_transmitting (is_transmitting)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; a byte leaves it when the drain side
  // is free (no frame awaiting start or in progress) and no flush is present.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  bit m_wait_start = 0, m_in_frame = 0;
  bit m_full, m_pop, m_push, e_ovf, e_tx;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      exp_q.delete();
      m_wait_start = 0;
      m_in_frame   = 0;
      e_ovf = 0;
      e_tx  = 0;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_pop  = !m_wait_start && !m_in_frame && mq.size() > 0 && !flush;
      m_push = wr_en && !m_full && !flush;
      e_ovf  = wr_en && m_full && !flush;
      if (m_wait_start && is_transmitting) begin
        m_wait_start = 0;
        m_in_frame   = 1;
      end else if (m_in_frame && !is_transmitting) begin
        m_in_frame = 0;
      end
      if (m_pop) begin
        exp_q.push_back(mq.pop_front());
        m_wait_start = 1;
      end
      if (m_push) mq.push_back(wr_data);
      if (flush) mq.delete();
      e_tx = m_pop;
    end
    #1;
    chk("count", int'(count), mq.size());
    chk("full", full, int'(mq.size() == DEPTH));
    chk("empty", empty, int'(mq.size() == 0));
    chk("overflow", overflow, e_ovf);
    chk("transmit", transmit, e_tx);
    chk("busy", busy, int'(m_wait_start || m_in_frame || mq.size() > 0));
    if (!rst) chk("tx_byte_reset", tx_byte, 0);
  end

  // Scoreboard monitor: each transmit pulse consumes one expected byte.
  logic [7:0] mon_byte;
  bit mon_act = 0, mon_seen_hi = 0;
  int n_tx = 0;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      mon_act = 0;
      mon_seen_hi = 0;
    end else if (transmit) begin
      chk("tx_while_busy", is_transmitting, 0);
      chk("tx_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("tx_byte", tx_byte, exp_q.pop_front());
      mon_byte = tx_byte;
      mon_act = 1;
      mon_seen_hi = 0;
      n_tx++;
    end else if (mon_act) begin
      chk("tx_byte_stable", tx_byte, mon_byte);
      if (is_transmitting) mon_seen_hi = 1;
      else if (mon_seen_hi) mon_act = 0;
    end
  end

  // Behavioural uart: starts a frame 1-3 cycles after the pulse, runs a few
  // cycles, and can be held busy to let the FIFO fill.
  int u_phase = 0;
  int u_cnt = 0;
  bit u_hold = 0;

  always @(negedge clk) begin
    if (!rst) begin
      is_transmitting = 1'b0;
      u_phase = 0;
    end else begin
      case (u_phase)
        0: if (transmit) begin
             u_cnt = int'($urandom_range(0, 2));
             u_phase = 1;
           end
        1: if (u_cnt == 0) begin
             is_transmitting = 1'b1;
             u_cnt = int'($urandom_range(2, 8));
             u_phase = 2;
           end else u_cnt--;
        default: if (u_cnt > 0) u_cnt--;
                 else if (!u_hold) begin
                   is_transmitting = 1'b0;
                   u_phase = 0;
                 end
      endcase
    end
  end

  task automatic write_burst(input int n, input int base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = rnd ? 8'($urandom) : 8'(base + i);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((busy || is_transmitting) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_in_time", int'(k < budget), 1);
  endtask

  task automatic wait_frame(input int budget);
    int k = 0;
    while (!is_transmitting && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("frame_started", is_transmitting, 1);
  endtask

  int tx_before;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    write_burst(1, 8'hA5, 0);
    drain(100);

    write_burst(5, 8'h01, 0);
    drain(300);

    u_hold = 1'b1;
    write_burst(18, 0, 1);
    chk("full_held", full, 1);
    chk("count_held", int'(count), DEPTH);
    u_hold = 1'b0;
    drain(800);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = 8'(i);
      @(negedge clk);
      wr_en = 1'b0;
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    drain(1500);
    chk("empty_after_wrap", empty, 1);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      wr_en = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom);
      flush = ($urandom_range(0, 29) == 0);
    end
    @(negedge clk);
    wr_en = 1'b0;
    flush = 1'b0;
    drain(2000);

    write_burst(4, 8'h40, 0);
    wait_frame(50);
    @(negedge clk);
    flush = 1'b1;
    tx_before = n_tx;
    @(negedge clk);
    flush = 1'b0;
    chk("count_after_flush", int'(count), 0);
    drain(200);
    chk("no_tx_after_flush", n_tx, tx_before);

    write_burst(1, 8'h3C, 0);
    wait_frame(50);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_transmit", transmit, 0);
    chk("async_tx_byte", tx_byte, 0);
    chk("async_count", int'(count), 0);
    chk("async_empty", empty, 1);
    chk("async_full", full, 0);
    chk("async_busy", busy, 0);
    chk("async_overflow", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tx_before = n_tx;
    write_burst(1, 8'h5A, 0);
    drain(100);
    chk("tx_after_reset", n_tx, tx_before + 1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer that sits directly upstream of the uart core.
- Accepts bytes from the CPU/bus side through a simple write strobe and stores them in a DEPTH-entry FIFO.
- Drains the FIFO into the uart through its transmit/tx_byte/is_transmitting handshake, one byte per uart frame.
- Frees the CPU from polling is_transmitting between bytes.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of 2, 2..256.
- AW, 4, pointer width, log2(DEPTH).

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- wr_en  input  1  write strobe: push wr_data this cycle.
- wr_data  input  8  byte to enqueue.
- flush  input  1  synchronous clear of FIFO contents.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write dropped because FIFO full.
- busy  output  1  high while FIFO non-empty or a byte is in flight.
- transmit  output  1  one-cycle start pulse to uart transmit.
- tx_byte  output  8  byte to uart tx_byte; held stable from the pulse until the frame ends.
- is_transmitting  input  1  uart is_transmitting status.

Behaviour:
- Reset (rst=0, asynchronous): pointers=0, count=0, empty=1, full=0, overflow=0, transmit=0, tx_byte=8'h00, busy=0, state=IDLE. Memory contents are don't-care.
- Storage: circular buffer, wr_ptr/rd_ptr are AW bits and wrap naturally from DEPTH-1 to 0. Count is kept separately (AW+1 bits). full=(count==DEPTH), empty=(count==0), both registered-consistent with count.
- Write: on wr_en&!full&!flush: mem[wr_ptr]<=wr_data, wr_ptr++, and count++ unless a pop occurs in the same cycle.
- Write while full: data dropped, overflow=1 for exactly that next cycle, no state change. A write when full is rejected even if a pop occurs in the same cycle.
- Pop: happens only in IDLE on the FSM transition described below. A simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, WAIT_START, WAIT_DONE.
- IDLE: if !empty: tx_byte<=mem[rd_ptr], rd_ptr++, count--, transmit<=1, go WAIT_START. Else stay.
- WAIT_START: transmit<=0. When is_transmitting==1, go WAIT_DONE.
- WAIT_DONE: when is_transmitting==0, go IDLE.
- Latency: wr_en at cycle N into an empty FIFO with FSM in IDLE gives count=1 in N+1 and transmit=1 with tx_byte valid in N+2.
- Throughput: back-to-back bytes need at least 1 IDLE cycle between frames. The next transmit pulse comes 1 cycle after is_transmitting falls.
- busy = (state!=IDLE) | !empty.
- flush: wr_ptr=rd_ptr=0, count=0 next cycle. A write in the same cycle is dropped without an overflow pulse. flush does not abort a byte already handed to the uart: FSM continues and tx_byte stays stable.
- flush coinciding with an IDLE pop: flush wins, no transmit pulse, FSM stays IDLE.
- Reset mid-frame: FSM returns to IDLE immediately. The uart core is reset by the same rst, so no handshake recovery is needed.

Decomposition:
- Shared package/include: FSM state encodings (ST_IDLE=2'd0, ST_WAIT_START=2'd1, ST_WAIT_DONE=2'd2).
- Natural sub-module: sync_fifo_ram, the DEPTH x 8 register array with write port and combinational read at rd_ptr.
- Pointers, count and FSM stay in uart_tx_fifo.

Test Plan:
- Single byte: reset, write 8'hA5 into empty FIFO -> count 1 next cycle; transmit pulse 1 cycle wide two cycles after write with tx_byte=8'hA5; busy falls after is_transmitting falls. Connected to a real uart looped to a second uart, receiver reports rx_byte=8'hA5.
- Burst: write 8'h01..8'h05 on consecutive cycles -> five frames in order 01,02,03,04,05; exactly one transmit pulse per frame; none while is_transmitting=1.
- Full/overflow (DEPTH=16, uart held busy): write 17 bytes -> full=1 and count=16 after the 16th; 17th gives a single overflow pulse and is never transmitted.
- Wrap-around: push/pop 40 bytes (0x00..0x27) at varying rates -> output sequence identical to input; count never exceeds 16; empty=1 at end.
- Flush mid-frame: 4 bytes queued, first frame in flight, assert flush -> count=0 next cycle; the in-flight byte completes with tx_byte unchanged; no further transmit pulses.
- Async reset mid-frame: drop rst between clk edges during WAIT_DONE -> all outputs at reset values before the next edge; after release, a new write transmits normally.
